// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter; one instance per master.
// The requester uses the master modport, the arbiter uses the slave modport.
interface ram_port_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  size;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, wdata, we, size,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, wdata, we, size,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter/sequencer in front of the single-port data RAM, 1-cycle response.
// Optional perf counters (perf_conflict_o, perf_boost_o) enabled by defining RAM_ARB_PERF_EN.
module ram_port_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_2000,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_port_arbiter_if.slave        m0,
  ram_port_arbiter_if.slave        m1,
  output logic [31:0]              ram_addr_o,
  output logic [31:0]              ram_data_o,
  output logic                     ram_we_o,
  output logic                     ram_re_o,
  output logic [2:0]               ram_size_o,
  input  logic [31:0]              ram_rdata_i
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]              perf_conflict_o,
  output logic [31:0]              perf_boost_o
`endif
);

  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        gnt0, gnt1, boost;
  logic [31:0] selAddr, selWdata;
  logic        selWe;
  logic [2:0]  selSize;
  logic        sizeOk, alignOk, legal;

  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // m0 has priority unless m1 has already lost MAX_WAIT times in a row.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    boost = 1'b0;
    if (!rst) begin
      if (m1.req && (!m0.req || waitCnt_q == WaitMax)) begin
        gnt1  = 1'b1;
        boost = m0.req;
      end else if (m0.req) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign m0.gnt   = gnt0;
  assign m1.gnt   = gnt1;

  assign selAddr  = gnt1 ? m1.addr  : m0.addr;
  assign selWdata = gnt1 ? m1.wdata : m0.wdata;
  assign selWe    = gnt1 ? m1.we    : m0.we;
  assign selSize  = gnt1 ? m1.size  : m0.size;

  always_comb begin
    sizeOk  = 1'b0;
    alignOk = 1'b0;
    case (selSize)
      3'b000, 3'b100: begin
        sizeOk  = 1'b1;
        alignOk = 1'b1;
      end
      3'b001, 3'b101: begin
        sizeOk  = 1'b1;
        alignOk = !selAddr[0];
      end
      3'b010: begin
        sizeOk  = 1'b1;
        alignOk = (selAddr[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  assign legal = (gnt0 || gnt1) && sizeOk && alignOk && (selAddr < ADDR_LIMIT);

  // A rejected access must leave the RAM port completely idle.
  assign ram_addr_o = legal ? selAddr  : '0;
  assign ram_data_o = legal ? selWdata : '0;
  assign ram_size_o = legal ? selSize  : '0;
  assign ram_we_o   = legal && selWe;
  assign ram_re_o   = legal && !selWe;

  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!m1.req || gnt1) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != WaitMax) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
  end

  always_comb begin
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    err0_d    = gnt0 && !legal;
    err1_d    = gnt1 && !legal;
    rdata0_d  = (gnt0 && legal && !selWe) ? ram_rdata_i : '0;
    rdata1_d  = (gnt1 && legal && !selWe) ? ram_rdata_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt_q <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Masking with rst drops a response that is already registered when reset arrives.
  assign m0.rvalid = rvalid0_q && !rst;
  assign m1.rvalid = rvalid1_q && !rst;
  assign m0.err    = err0_q && !rst;
  assign m1.err    = err1_q && !rst;
  assign m0.rdata  = rst ? '0 : rdata0_q;
  assign m1.rdata  = rst ? '0 : rdata1_q;

`ifdef RAM_ARB_PERF_EN
  logic [31:0] perfConflict_q, perfConflict_d;
  logic [31:0] perfBoost_q, perfBoost_d;

  always_comb begin
    perfConflict_d = perfConflict_q + ((m0.req && m1.req) ? 32'd1 : 32'd0);
    perfBoost_d    = perfBoost_q + (boost ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perfConflict_q <= '0;
      perfBoost_q    <= '0;
    end else begin
      perfConflict_q <= perfConflict_d;
      perfBoost_q    <= perfBoost_d;
    end
  end

  assign perf_conflict_o = perfConflict_q;
  assign perf_boost_o    = perfBoost_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by randomized traffic,
// compared against a byte-addressed reference memory and a rule-level arbitration model.
module tb_ram_port_arbiter;

  localparam int          MaxWait = 4;
  localparam logic [31:0] Limit   = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if m0If ();
  ram_port_arbiter_if m1If ();

  logic [31:0] ramAddr, ramData, ramRdata, ramWord;
  logic        ramWe, ramRe;
  logic [2:0]  ramSize;
`ifdef RAM_ARB_PERF_EN
  logic [31:0] perfConflict, perfBoost;
`endif

  ram_port_arbiter #(.ADDR_LIMIT(Limit), .MAX_WAIT(MaxWait)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0If),
    .m1          (m1If),
    .ram_addr_o  (ramAddr),
    .ram_data_o  (ramData),
    .ram_we_o    (ramWe),
    .ram_re_o    (ramRe),
    .ram_size_o  (ramSize),
    .ram_rdata_i (ramRdata)
`ifdef RAM_ARB_PERF_EN
    ,
    .perf_conflict_o (perfConflict),
    .perf_boost_o    (perfBoost)
`endif
  );

  // RAM environment: word array with combinational sized read.
  logic [31:0] ramWords [2048];

  always_comb begin
    ramWord = ramWords[ramAddr[12:2]] >> {ramAddr[1:0], 3'b000};
    case (ramSize)
      3'b000:  ramRdata = {{24{ramWord[7]}}, ramWord[7:0]};
      3'b100:  ramRdata = {24'd0, ramWord[7:0]};
      3'b001:  ramRdata = {{16{ramWord[15]}}, ramWord[15:0]};
      3'b101:  ramRdata = {16'd0, ramWord[15:0]};
      default: ramRdata = ramWord;
    endcase
  end

  // Reference model state.
  logic [7:0]  refMem [8192];
  int          m1Waited;
  int          prevWin;
  logic        prevErr;
  logic [31:0] prevData;
  logic [31:0] expConflict, expBoost;
  int          expWin;
  logic        obsGnt1, obsRv0;
  logic [31:0] obsRd0;
  int          nChecks = 0;
  int          nFail   = 0;

  function automatic logic [31:0] preloadWord(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0000_1357;
  endfunction

  function automatic int sizeBytes(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit legalRef(input logic [31:0] a, input logic [2:0] s);
    int nb;
    nb = sizeBytes(s);
    if (nb == 0) return 1'b0;
    return ((a % 32'(nb)) == 32'd0) && (a < Limit);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] v;
    int nb;
    nb = sizeBytes(s);
    v  = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(refMem[int'(a) + i]) << (8 * i));
    if (s == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (s == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic we, input logic [2:0] size);
    if (m == 0) begin
      m0If.req = req; m0If.addr = addr; m0If.wdata = wdata; m0If.we = we; m0If.size = size;
    end else begin
      m1If.req = req; m1If.addr = addr; m1If.wdata = wdata; m1If.we = we; m1If.size = size;
    end
  endtask

  task automatic randomReq(input int m);
    logic [31:0] a;
    logic [2:0]  s;
    int          k, nb;
    k = $urandom_range(0, 9);
    case ($urandom_range(0, 6))
      0: s = 3'b000;
      1: s = 3'b001;
      2: s = 3'b010;
      3: s = 3'b100;
      4: s = 3'b101;
      5: s = 3'b010;
      default: s = 3'($urandom_range(0, 7));
    endcase
    a  = (k == 0) ? 32'($urandom_range(32'h1FF0, 32'h2010)) : 32'($urandom_range(0, 127));
    nb = sizeBytes(s);
    if (k > 2 && nb > 0) a = a - (a % 32'(nb));
    applyStimulus(m, 1'b1, a, $urandom, 1'($urandom_range(0, 1)), s);
  endtask

  // One clock cycle: check responses and grant-cycle outputs at negedge, then advance the model.
  task automatic runCycle();
    logic        m0r, m1r, lgl, wWe, sWe;
    logic [31:0] wAddr, wData, expRd, sAddr, sData;
    logic [2:0]  wSize, sSize;
    int          win, nb;
    @(negedge clk);
    m0r = m0If.req;
    m1r = m1If.req;
    obsGnt1 = m1If.gnt;
    obsRv0  = m0If.rvalid;
    obsRd0  = m0If.rdata;
    checkOutput("m0_rvalid", 32'(m0If.rvalid), 32'(prevWin == 0 && !rst));
    checkOutput("m1_rvalid", 32'(m1If.rvalid), 32'(prevWin == 1 && !rst));
    if (prevWin == 0 && !rst) begin
      checkOutput("m0_err", 32'(m0If.err), 32'(prevErr));
      checkOutput("m0_rdata", m0If.rdata, prevData);
    end
    if (prevWin == 1 && !rst) begin
      checkOutput("m1_err", 32'(m1If.err), 32'(prevErr));
      checkOutput("m1_rdata", m1If.rdata, prevData);
    end
    win = -1;
    if (!rst) begin
      if (m1r && (!m0r || m1Waited >= MaxWait)) win = 1;
      else if (m0r) win = 0;
    end
    expWin = win;
    checkOutput("m0_gnt", 32'(m0If.gnt), 32'(win == 0));
    checkOutput("m1_gnt", 32'(m1If.gnt), 32'(win == 1));
    wAddr = (win == 1) ? m1If.addr  : m0If.addr;
    wData = (win == 1) ? m1If.wdata : m0If.wdata;
    wWe   = (win == 1) ? m1If.we    : m0If.we;
    wSize = (win == 1) ? m1If.size  : m0If.size;
    lgl   = (win >= 0) && legalRef(wAddr, wSize);
    expRd = (lgl && !wWe) ? refLoad(wAddr, wSize) : 32'd0;
    checkOutput("ram_we", 32'(ramWe), 32'(lgl && wWe));
    checkOutput("ram_re", 32'(ramRe), 32'(lgl && !wWe));
    checkOutput("ram_addr", ramAddr, lgl ? wAddr : 32'd0);
    checkOutput("ram_data", ramData, lgl ? wData : 32'd0);
    checkOutput("ram_size", 32'(ramSize), lgl ? 32'(wSize) : 32'd0);
`ifdef RAM_ARB_PERF_EN
    checkOutput("perf_conflict", perfConflict, expConflict);
    checkOutput("perf_boost", perfBoost, expBoost);
`endif
    sWe = ramWe; sAddr = ramAddr; sData = ramData; sSize = ramSize;
    @(posedge clk);
    #1;
    if (rst) begin
      m1Waited = 0; prevWin = -1; prevErr = 1'b0; prevData = '0;
      expConflict = '0; expBoost = '0;
    end else begin
      if (lgl && wWe) begin
        nb = sizeBytes(wSize);
        for (int i = 0; i < nb; i++) refMem[int'(wAddr) + i] = wData[8*i +: 8];
      end
      m1Waited = (m1r && win != 1) ? m1Waited + 1 : 0;
      if (m0r && m1r) expConflict = expConflict + 1;
      if (win == 1 && m0r) expBoost = expBoost + 1;
      prevWin = win; prevErr = !lgl; prevData = expRd;
    end
    if (sWe) begin
      nb = sizeBytes(sSize);
      for (int i = 0; i < nb; i++)
        ramWords[sAddr[12:2]][8*(int'(sAddr[1:0]) + i) +: 8] = sData[8*i +: 8];
    end
  endtask

  initial begin
    int boostAt;
    logic [31:0] word;
    for (int i = 0; i < 2048; i++) begin
      word = preloadWord(i);
      ramWords[i] = word;
      for (int j = 0; j < 4; j++) refMem[4*i + j] = word[8*j +: 8];
    end
    m1Waited = 0; prevWin = -1; prevErr = 1'b0; prevData = '0;
    expConflict = '0; expBoost = '0; expWin = -1;
    rst = 1'b1;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    applyStimulus(1, 1'b1, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();
    runCycle();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    rst = 1'b0;
    runCycle();

    // Store, reload, and byte reload of the same word.
    applyStimulus(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 3'b010);
    runCycle();
    applyStimulus(0, 1'b1, 32'h100, 32'd0, 1'b0, 3'b010);
    runCycle();
    applyStimulus(0, 1'b1, 32'h103, 32'd0, 1'b0, 3'b100);
    runCycle();
    checkOutput("lw_after_sw", obsRd0, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();
    checkOutput("lbu_0x103", obsRd0, 32'h0000_00DE);

    // Simultaneous requests, m0 then drops.
    applyStimulus(0, 1'b1, 32'h200, 32'd0, 1'b0, 3'b010);
    applyStimulus(1, 1'b1, 32'h204, 32'd0, 1'b0, 3'b010);
    runCycle();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();

    // Starvation: m1 must win in the fifth contested cycle.
    applyStimulus(1, 1'b1, 32'h10, 32'd0, 1'b0, 3'b010);
    applyStimulus(0, 1'b1, 32'h20, 32'd0, 1'b0, 3'b010);
    boostAt = -1;
    for (int c = 0; c < 8; c++) begin
      runCycle();
      if (obsGnt1 && boostAt < 0) begin
        boostAt = c;
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
      end
    end
    checkOutput("boost_cycle", 32'(boostAt), 32'd4);
`ifdef RAM_ARB_PERF_EN
    checkOutput("perf_boost_once", perfBoost, 32'd1);
`endif
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();

    // Illegal accesses: misaligned half, out of range word, bad size code.
    applyStimulus(1, 1'b1, 32'h101, 32'd0, 1'b0, 3'b001);
    runCycle();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    applyStimulus(0, 1'b1, 32'h2000, 32'h1234_5678, 1'b1, 3'b010);
    runCycle();
    applyStimulus(0, 1'b1, 32'h0, 32'd0, 1'b0, 3'b011);
    runCycle();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();

    // Reset while a load response is pending.
    applyStimulus(0, 1'b1, 32'h8, 32'd0, 1'b0, 3'b010);
    runCycle();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    rst = 1'b1;
    runCycle();
    checkOutput("rvalid_in_reset", 32'(obsRv0), 32'd0);
    runCycle();
    rst = 1'b0;
    runCycle();

    // Back-to-back loads of preloaded words.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) applyStimulus(0, 1'b1, 32'(4 * i), 32'd0, 1'b0, 3'b010);
      else       applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
      runCycle();
      if (i > 0) begin
        checkOutput("b2b_rvalid", 32'(obsRv0), 32'd1);
        checkOutput("b2b_rdata", obsRd0, preloadWord(i - 1));
      end
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!m0If.req || expWin == 0) begin
        if ($urandom_range(0, 3) != 0) randomReq(0);
        else applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
      end
      if (!m1If.req || expWin == 1) begin
        if ($urandom_range(0, 2) != 0) randomReq(1);
        else applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
      end
      runCycle();
    end
    rst = 1'b0;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'b010);
    runCycle();
    runCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data RAM (combinational read, synchronous byte-enable write, size codes 000 b / 001 h / 010 w / 100 bu / 101 hu).
- Master 0 is the pipeline load/store unit. Master 1 is the debug/program loader.
- Grants one access per cycle and drives the RAM port.
- Registers read data into a 1-cycle-latency response.
- Rejects misaligned or out-of-range accesses with an error response; the RAM is never touched for a rejected access.

Parameters:
- ADDR_LIMIT, 32'h0000_2000: first illegal byte address (2048 words).
- MAX_WAIT, 4: cycles master 1 may lose arbitration before it is forced ahead of master 0. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mN_req_i  in  1  access request (N = 0, 1)
- mN_addr_i  in  32  byte address
- mN_wdata_i  in  32  store data, low-aligned
- mN_we_i  in  1  1 = store, 0 = load
- mN_size_i  in  3  size code, same encoding as the RAM
- mN_gnt_o  out  1  request accepted this cycle (combinational)
- mN_rvalid_o  out  1  response valid, 1-cycle pulse
- mN_rdata_o  out  32  load data; 0 for stores and errors
- mN_err_o  out  1  error flag, qualified by mN_rvalid_o
- ram_addr_o  out  32  RAM address
- ram_data_o  out  32  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_re_o  out  1  RAM read enable
- ram_size_o  out  3  RAM size code
- ram_rdata_i  in  32  RAM read data (combinational)

Behaviour:

Reset and request rules
- Reset (synchronous, active-high) clears: all rvalid, err and rdata registers, the wait counter, and the perf counters.
- During reset, all gnt and ram_* outputs are 0.
- A response pending when reset is asserted is discarded; rvalid stays 0.
- A requester holds req/addr/wdata/we/size stable until gnt. It may issue a new request in the cycle after gnt (back-to-back, no bubble).

Arbitration (combinational, each cycle)
- Only m0_req: m0 wins.
- Only m1_req: m1 wins.
- Both requesting: m0 wins unless wait_cnt == MAX_WAIT, in which case m1 wins.
- At most one gnt is asserted per cycle.

wait_cnt (4-bit)
- Increments when m1_req && !m1_gnt, saturating at MAX_WAIT.
- Clears to 0 on m1_gnt, or when m1_req is low.

Legality check on the winning request
- Illegal if size is not one of {000, 001, 010, 100, 101}.
- Illegal if halfword (001/101) and addr[0] = 1.
- Illegal if word (010) and addr[1:0] != 0.
- Illegal if addr >= ADDR_LIMIT.

RAM drive in the grant cycle
- Legal access: ram_addr/data/size = the winner's fields; ram_we_o = we; ram_re_o = !we.
- Illegal access, or no grant: ram_we_o = 0, ram_re_o = 0, ram_addr_o/data_o/size_o = 0.
- Gnt is still asserted for an illegal access.

Response, on the posedge after the grant cycle
- Winner's rvalid = 1 for exactly one cycle.
- err = 1 if the access was illegal, else 0.
- rdata = ram_rdata_i captured at that posedge for a legal load, else 0.
- The non-winner's rvalid = 0.
- Back-to-back grants to the same master give back-to-back rvalid pulses.

Other rules
- Stores always receive an ack (rvalid with err = 0 or 1).
- Latency is fixed at 1 cycle; there is no backpressure on responses.
- Simultaneous store by one master and load by the other cannot occur (single grant). Store-then-load to the same address in consecutive cycles returns the new data.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined: adds output ports perf_conflict_o [31:0] and perf_boost_o [31:0].
  - perf_conflict_o counts cycles with m0_req && m1_req.
  - perf_boost_o counts grants to m1 forced by wait_cnt == MAX_WAIT.
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store then load, with m1 idle:
  - Cycle 0: m0 sw 0xDEADBEEF @0x100. Gnt the same cycle; ram_we_o = 1; rvalid/err = 1/0 next cycle.
  - Cycle 1: m0 lw @0x100. rvalid in cycle 2 with rdata 0xDEADBEEF.
  - Follow-up m0 lbu @0x103 returns 0x000000DE.
- Simultaneous req, m0 single access then dropping req: m0_gnt in cycle 0, m1_gnt in cycle 1, m1_rvalid in cycle 2; never both gnts high.
- Starvation, MAX_WAIT = 4, m0_req held high, m1_req raised in cycle 0:
  - m1_gnt first in cycle 4, with m0_gnt = 0 in that cycle.
  - wait_cnt = 0 in cycle 5.
  - With RAM_ARB_PERF_EN defined, perf_boost_o = 1.
- Misaligned and out-of-range accesses: m1 lh @0x101, m0 lw @0x2000, and size 011. Each gets gnt, then rvalid with err = 1 and rdata 0; ram_we_o and ram_re_o stay 0 throughout.
- Reset mid-response: m0 lw granted in cycle 0, rst high in cycle 1. m0_rvalid_o = 0 from the cycle-1 posedge onward; wait_cnt = 0.
- Back-to-back: m0 issues 4 consecutive lw @0x0, 0x4, 0x8, 0xC with m1 idle. 4 consecutive rvalid pulses carry the preloaded words in order.
